// File: rtl/shift_add_multiplication_v1_0_pkg.sv
// Shared typedefs for the multiplier self-check and the divider cores.
// Package is named division_pkg so the dividers can import the same file.
package division_pkg;

  localparam int INOUT_WIDTH  = 12;
  localparam int RESULT_WIDTH = 2 * INOUT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    SIGN,
    ACC
  } mult_state_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/shift_add_multiplication_v1_0_if.sv
// Operand/result bundle with data_valid/data_ready handshake.
// The overflow signal exists only when MULT_OVERFLOW_EN is defined.
interface shift_add_multiplication_v1_0_if
  import division_pkg::*;
#(
  parameter int W = INOUT_WIDTH
);

  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic           data_valid;
  logic [2*W-1:0] result;
  logic           data_ready;
  logic           busy;
`ifdef MULT_OVERFLOW_EN
  logic           overflow;
`endif

  modport master (
    output multiplicand,
    output multiplier,
    output addend,
    output data_valid,
    input  result,
    input  data_ready,
`ifdef MULT_OVERFLOW_EN
    input  overflow,
`endif
    input  busy
  );

  modport slave (
    input  multiplicand,
    input  multiplier,
    input  addend,
    input  data_valid,
    output result,
    output data_ready,
`ifdef MULT_OVERFLOW_EN
    output overflow,
`endif
    output busy
  );

endinterface

// File: rtl/shift_add_multiplication_v1_0_sign_magnitude_conv.sv
// Two's complement to sign/magnitude; the most negative value
// maps to 2^(W-1), which still fits as W-bit unsigned.
module sign_magnitude_conv #(
  parameter int W = 12
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] mag,
  output logic         sign
);

  assign sign = value[W-1];
  assign mag  = sign ? (~value + 1'b1) : value;

endmodule

// File: rtl/shift_add_multiplication_v1_0.sv
// Iterative signed shift-add multiply-accumulate: A*B + addend.
// Define MULT_OVERFLOW_EN to add a W-bit range flag on the result.
module shift_add_multiplication_v1_0
  import division_pkg::*;
#(
  parameter int inout_width = INOUT_WIDTH
) (
  input logic aclk,
  input logic resetn,
  shift_add_multiplication_v1_0_if.slave bus
);

  localparam int W  = inout_width;
  localparam int RW = 2 * W;
  localparam int CW = $clog2(W);

  mult_state_t   state;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_sh;
  logic          neg;
  logic [RW-1:0] add_ext;
  logic [RW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [W-1:0]  a_abs;
  logic [W-1:0]  b_abs;
  logic          a_sign;
  logic          b_sign;
  logic [RW-1:0] part;
  logic [RW-1:0] sum;

  sign_magnitude_conv #(.W(W)) conv_a (
    .value (bus.multiplicand),
    .mag   (a_abs),
    .sign  (a_sign)
  );

  sign_magnitude_conv #(.W(W)) conv_b (
    .value (bus.multiplier),
    .mag   (b_abs),
    .sign  (b_sign)
  );

  assign part = RW'(a_mag) << cnt;
  assign sum  = acc + add_ext;

`ifdef MULT_OVERFLOW_EN
  // In range only if the top W+1 bits are a pure sign extension.
  logic ovf;
  assign ovf = (sum[RW-1:W-1] != '0) &&
               (sum[RW-1:W-1] != '1);
`endif

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      a_mag          <= '0;
      b_sh           <= '0;
      neg            <= 1'b0;
      add_ext        <= '0;
      acc            <= '0;
      cnt            <= '0;
      bus.result     <= '0;
      bus.data_ready <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef MULT_OVERFLOW_EN
      bus.overflow   <= 1'b0;
`endif
    end else begin
      bus.data_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.busy <= bus.data_valid;
          if (bus.data_valid) begin
            a_mag   <= a_abs;
            b_sh    <= b_abs;
            neg     <= a_sign ^ b_sign;
            add_ext <= {{W{bus.addend[W-1]}},
                        bus.addend};
            acc     <= '0;
            cnt     <= '0;
            state   <= ITER;
          end
        end
        ITER: begin
          if (b_sh[0])
            acc <= acc + part;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W - 1))
            state <= SIGN;
        end
        SIGN: begin
          if (neg)
            acc <= ~acc + 1'b1;
          state <= ACC;
        end
        ACC: begin
          bus.result     <= sum;
          bus.data_ready <= 1'b1;
`ifdef MULT_OVERFLOW_EN
          bus.overflow   <= ovf;
`endif
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
